// File: rtl/calc_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//
// Contents:
//   OP_MUL / OP_MULH / OP_DIV / OP_REM - operation encodings on in_op
//   state_t                            - FSM state encoding
//   cnt_width()                        - step-counter width for a given operand width
//   CNT_W                              - counter width at the default 32-bit operand width
package calc_pkg;

   localparam logic [1:0] OP_MUL  = 2'd0;  // low half of product
   localparam logic [1:0] OP_MULH = 2'd1;  // high half of product
   localparam logic [1:0] OP_DIV  = 2'd2;  // quotient
   localparam logic [1:0] OP_REM  = 2'd3;  // remainder

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // One spare bit above $clog2 so the counter can also hold WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   localparam int DEFAULT_WIDTH = 32;
   localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/calc_negate_abs.sv
// Combinational conditional two's-complement negation.
// Used both to take absolute values of signed operands and to restore the
// sign of the result.
//
// Ports:
//   neg    - 1: result = -value, 0: result = value
//   value  - N-bit input word
//   result - N-bit output word
module calc_negate_abs #(
   parameter int N = 32
) (
   input  logic         neg,
   input  logic [N-1:0] value,
   output logic [N-1:0] result
);

   assign result = neg ? ((~value) + {{(N-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/calc_muldiv_unit.sv
// Iterative multiply/divide unit: MUL, MULH, DIV, REM, signed or unsigned,
// one result bit per clock on the single core clock.
//
// Ports:
//   clk0        - core clock, rising edge
//   reset       - asynchronous active-low reset
//   in_valid / in_ready / in_op / in_signed / in_a / in_b / in_tag - request side
//   out_valid / out_ready / out_result / out_tag / out_dbz         - result side
//   busy        - unit is not in IDLE
//   dbg_state   - current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising clk0 edge where valid and ready
// are both high. The request side is ready only in IDLE; the result side
// holds out_result/out_tag/out_dbz stable in DONE until out_ready is seen.
//
// Build option: define CALC_MULDIV_EARLY_OUT_EN to let PREP bypass the
// iteration for trivial operands (zero multiply operand, zero divisor,
// |dividend| < |divisor|). Without it, latency is always WIDTH+3 edges.
module calc_muldiv_unit
   import calc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk0,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dbz,
   output logic             busy,
   output logic [2:0]       dbg_state
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t state_q, state_d;

   logic [1:0]         op_q;
   logic               sgn_q;
   logic               neg_q;    // final result must be negated
   logic               dbz_q;
   logic [WIDTH-1:0]   a_q;      // multiplicand / dividend (shifts left while dividing)
   logic [WIDTH-1:0]   b_q;      // multiplier (shifts right) / divisor
   logic [TAG_W-1:0]   tag_q;
   logic [2*WIDTH-1:0] acc_q;    // product, or {remainder, quotient}
   logic [CW-1:0]      cnt_q;

   logic is_div;
   assign is_div = (op_q == OP_DIV) || (op_q == OP_REM);

   // ---------------- PREP: absolute values and result sign ----------------
   logic             a_neg, b_neg, res_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   assign a_neg   = sgn_q & a_q[WIDTH-1];
   assign b_neg   = sgn_q & b_q[WIDTH-1];
   // Remainder takes the dividend's sign; everything else is sign(a)^sign(b).
   assign res_neg = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);

   calc_negate_abs #(.N(WIDTH)) u_abs_a (.neg(a_neg), .value(a_q), .result(a_abs));
   calc_negate_abs #(.N(WIDTH)) u_abs_b (.neg(b_neg), .value(b_q), .result(b_abs));

   // ---------------- RUN: one multiply or divide step ----------------
   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_add  = b_q[0] ? a_q : {WIDTH{1'b0}};
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff, div_rem;
   logic [2*WIDTH-1:0] div_next;

   // Bring the next dividend bit into the partial remainder, then subtract
   // the divisor if it fits (restoring division).
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   // When div_ge holds the true difference is below 2^WIDTH, so the
   // truncated subtraction is exact.
   assign div_diff  = div_shift[WIDTH-1:0] - b_q;
   assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
   assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

   // ---------------- FIX: sign correction and word select ----------------
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_word, div_fix, fix_result;

   // The product is negated as a whole so the carry out of the low half
   // reaches the high half.
   calc_negate_abs #(.N(2*WIDTH)) u_fix_prod (.neg(neg_q), .value(acc_q), .result(prod_fix));

   assign div_word = (op_q == OP_REM) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
   calc_negate_abs #(.N(WIDTH)) u_fix_div (.neg(neg_q), .value(div_word), .result(div_fix));

   // Divide by zero: the restoring loop already leaves |a| as the
   // remainder, and REM's sign rule turns that back into a. Only the
   // quotient needs forcing to all ones.
   always_comb begin
      fix_result = div_fix;
      case (op_q)
         OP_MUL:  fix_result = prod_fix[WIDTH-1:0];
         OP_MULH: fix_result = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV:  fix_result = dbz_q ? {WIDTH{1'b1}} : div_fix;
         default: fix_result = div_fix;
      endcase
   end

`ifdef CALC_MULDIV_EARLY_OUT_EN
   logic               early_hit;
   logic               early_div0;
   logic [2*WIDTH-1:0] early_acc;

   assign early_div0 = is_div && (b_q == '0);
   assign early_hit  = is_div ? (early_div0 || (a_abs < b_abs))
                              : ((a_q == '0) || (b_q == '0));
   // Direct results in the same {remainder, quotient} / product layout
   // the iteration would have produced.
   assign early_acc  = is_div ? {a_abs, (early_div0 ? {WIDTH{1'b1}} : {WIDTH{1'b0}})}
                              : {(2*WIDTH){1'b0}};
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy     = 1'b0;
            // Held low while reset is asserted.
            in_ready = reset;
            if (in_valid && reset) state_d = ST_PREP;
         end
         ST_PREP: begin
`ifdef CALC_MULDIV_EARLY_OUT_EN
            state_d = early_hit ? ST_FIX : ST_RUN;
`else
            state_d = ST_RUN;
`endif
         end
         ST_RUN: begin
            if (cnt_q == CNT_LAST) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign dbg_state = state_q;

   // ---------------- Datapath ----------------
   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) begin
         op_q       <= '0;
         sgn_q      <= 1'b0;
         neg_q      <= 1'b0;
         dbz_q      <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         tag_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_result <= '0;
         out_tag    <= '0;
         out_dbz    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  op_q  <= in_op;
                  sgn_q <= in_signed;
                  a_q   <= in_a;
                  b_q   <= in_b;
                  tag_q <= in_tag;
               end
            end
            ST_PREP: begin
               a_q   <= a_abs;
               b_q   <= b_abs;
               neg_q <= res_neg;
               dbz_q <= is_div && (b_q == '0);
               acc_q <= '0;
               cnt_q <= '0;
`ifdef CALC_MULDIV_EARLY_OUT_EN
               if (early_hit) acc_q <= early_acc;
`endif
            end
            ST_RUN: begin
               cnt_q <= cnt_q + CW'(1);
               if (is_div) begin
                  acc_q <= div_next;
                  a_q   <= {a_q[WIDTH-2:0], 1'b0};
               end else begin
                  acc_q <= mul_next;
                  b_q   <= {1'b0, b_q[WIDTH-1:1]};
               end
            end
            ST_FIX: begin
               out_result <= fix_result;
               out_tag    <= tag_q;
               out_dbz    <= dbz_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_muldiv_unit.sv
// Bench for calc_muldiv_unit (default build, WIDTH=32, TAG_W=5).
// Directed vectors with hand-computed results go through a driver that
// pushes {dbz, tag, result} into exp_q; a negedge monitor pops and compares
// on every result handshake and checks the accept-to-out_valid latency.
module tb_calc_muldiv_unit;
   import calc_pkg::*;

   localparam int W  = 32;
   localparam int TW = 5;
   localparam int EW = W + TW + 1;
   localparam int LATENCY = W + 3;

   logic          clk0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_op;
   logic          in_signed;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic [TW-1:0] out_tag;
   logic          out_dbz;
   logic          busy;
   logic [2:0]    dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [EW-1:0] exp_q[$];

   calc_muldiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk0       (clk0),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_signed  (in_signed),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_dbz    (out_dbz),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Driver: wait for in_ready, queue the expected response, present the request for one edge.
   task automatic send(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag,
                       input logic [W-1:0] res, input logic dbz, input bit push);
      int guard = 0;
      while (!in_ready && guard < 500) begin
         @(posedge clk0); #1;
         guard++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_wait actual=in_ready_low required=in_ready_high");
         return;
      end
      if (push) exp_q.push_back({dbz, tag, res});
      in_valid  = 1'b1;
      in_op     = op;
      in_signed = sgn;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      @(posedge clk0); #1;
      // Scramble operands after the accept edge; the unit must ignore them.
      in_valid  = 1'b0;
      in_a      = $urandom();
      in_b      = $urandom();
      in_tag    = TW'($urandom_range(0, 31));
   endtask

   task automatic wait_drain();
      int guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 1000) begin
         @(posedge clk0); #1;
         guard++;
      end
      chk("drain_pending", W'(exp_q.size()), '0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit lat_pending = 0;
   int lat_edges   = 0;

   always @(negedge clk0) begin
      if (!reset) begin
         lat_pending = 0;
      end else begin
         if (lat_pending) begin
            lat_edges++;
            if (out_valid) begin
               lat_pending = 0;
               checks++;
               if (lat_edges != LATENCY) begin
                  failures++;
                  $display("FAIL latency actual=%0d required=%0d", lat_edges, LATENCY);
               end
            end
         end
         if (in_valid && in_ready) begin
            lat_pending = 1;
            lat_edges   = 0;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result actual=%h tag=%h required=none", out_result, out_tag);
            end else begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               if ({out_dbz, out_tag, out_result} !== e) begin
                  failures++;
                  $display("FAIL result actual dbz=%b tag=%h res=%h required dbz=%b tag=%h res=%h",
                           out_dbz, out_tag, out_result, e[EW-1], e[EW-2:W], e[W-1:0]);
               end
            end
         end
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0]    op;
      logic          sgn;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [TW-1:0] tag;
      logic [W-1:0]  res;
      logic          dbz;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   initial begin
      vecs[0]  = '{OP_MUL,  1'b0, 32'd7,        32'd6,        5'h0A, 32'd42,       1'b0};
      vecs[1]  = '{OP_MUL,  1'b1, 32'hFFFFFFFD, 32'd5,        5'h01, 32'hFFFFFFF1, 1'b0};
      vecs[2]  = '{OP_MULH, 1'b1, 32'hFFFFFFFD, 32'd5,        5'h02, 32'hFFFFFFFF, 1'b0};
      vecs[3]  = '{OP_MULH, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 1'b0};
      vecs[4]  = '{OP_MUL,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 32'h00000001, 1'b0};
      vecs[5]  = '{OP_MULH, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h05, 32'h00000000, 1'b0};
      vecs[6]  = '{OP_MULH, 1'b0, 32'h00010000, 32'h00010000, 5'h06, 32'h00000001, 1'b0};
      vecs[7]  = '{OP_DIV,  1'b0, 32'd100,      32'd7,        5'h07, 32'd14,       1'b0};
      vecs[8]  = '{OP_REM,  1'b0, 32'd100,      32'd7,        5'h08, 32'd2,        1'b0};
      vecs[9]  = '{OP_DIV,  1'b1, 32'hFFFFFF9C, 32'd7,        5'h09, 32'hFFFFFFF2, 1'b0};
      vecs[10] = '{OP_REM,  1'b1, 32'hFFFFFF9C, 32'd7,        5'h0B, 32'hFFFFFFFE, 1'b0};
      vecs[11] = '{OP_DIV,  1'b1, 32'd100,      32'hFFFFFFF9, 5'h0C, 32'hFFFFFFF2, 1'b0};
      vecs[12] = '{OP_REM,  1'b1, 32'd100,      32'hFFFFFFF9, 5'h0D, 32'd2,        1'b0};
      vecs[13] = '{OP_DIV,  1'b0, 32'd5,        32'd0,        5'h0E, 32'hFFFFFFFF, 1'b1};
      vecs[14] = '{OP_REM,  1'b0, 32'd5,        32'd0,        5'h0F, 32'd5,        1'b1};
      vecs[15] = '{OP_REM,  1'b1, 32'hFFFFFFFB, 32'd0,        5'h10, 32'hFFFFFFFB, 1'b1};
      vecs[16] = '{OP_DIV,  1'b1, 32'h80000000, 32'hFFFFFFFF, 5'h11, 32'h80000000, 1'b0};
      vecs[17] = '{OP_REM,  1'b1, 32'h80000000, 32'hFFFFFFFF, 5'h12, 32'h00000000, 1'b0};
   end

   // ---------------- main sequence ----------------
   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'd0;
      in_signed = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk0);
      #1;
      chk("rst_in_ready",   W'(in_ready),   '0);
      chk("rst_out_valid",  W'(out_valid),  '0);
      chk("rst_busy",       W'(busy),       '0);
      chk("rst_out_result", out_result,     '0);
      chk("rst_out_tag",    W'(out_tag),    '0);
      chk("rst_out_dbz",    W'(out_dbz),    '0);

      reset = 1'b1;
      #1;
      chk("post_rst_in_ready", W'(in_ready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         send(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag,
              vecs[i].res, vecs[i].dbz, 1'b1);
      end
      wait_drain();

      // Backpressure: result held in DONE, new requests ignored.
      out_ready = 1'b0;
      send(OP_MUL, 1'b0, 32'd3, 32'd4, 5'h13, 32'd12, 1'b0, 1'b1);
      begin
         int guard = 0;
         while (!out_valid && guard < 200) begin
            @(posedge clk0); #1;
            guard++;
         end
      end
      chk("bp_out_valid_seen", W'(out_valid), 32'd1);
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1'b1;
         in_op     = OP_MUL;
         in_a      = 32'd99;
         in_b      = 32'd99;
         in_tag    = 5'h1F;
         @(negedge clk0);
         chk("bp_out_valid",  W'(out_valid), 32'd1);
         chk("bp_out_result", out_result,    32'd12);
         chk("bp_out_tag",    W'(out_tag),   32'h13);
         chk("bp_in_ready",   W'(in_ready),  '0);
         @(posedge clk0); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk0);
      chk("hs_in_ready_same_cycle", W'(in_ready), '0);
      @(negedge clk0);
      chk("hs_in_ready_next", W'(in_ready),  32'd1);
      chk("hs_out_valid_low", W'(out_valid), '0);
      wait_drain();

      // Reset in the middle of RUN: operation discarded.
      @(posedge clk0); #1;
      send(OP_MUL, 1'b0, 32'd1234, 32'd5678, 5'h15, 32'd0, 1'b0, 1'b0);
      repeat (11) @(posedge clk0);
      #1;
      chk("pre_midrst_busy", W'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst_out_valid",  W'(out_valid), '0);
      chk("midrst_busy",       W'(busy),      '0);
      chk("midrst_in_ready",   W'(in_ready),  '0);
      chk("midrst_out_result", out_result,    '0);
      chk("midrst_out_tag",    W'(out_tag),   '0);
      chk("midrst_out_dbz",    W'(out_dbz),   '0);
      repeat (2) @(posedge clk0);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_release_in_ready", W'(in_ready), 32'd1);
      send(OP_MUL, 1'b0, 32'd9, 32'd9, 5'h16, 32'd81, 1'b0, 1'b1);
      wait_drain();

      repeat (5) @(posedge clk0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/calc_muldiv_unit.md
Name: calc_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the calculator datapath. It replaces the old arrangement of a fast multiplier clock (clk1) beside the slow core clock. It runs on the single core clock with a valid/ready handshake on both sides. It supports MUL, MULH, DIV and REM, each signed or unsigned, and retires one bit per cycle.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, even)
TAG_W, 5, width of the destination-register tag carried alongside the op

Ports:
clk0  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion, release synchronous to clk0
in_valid  input  1  request valid
in_ready  output  1  unit can accept; high only in IDLE
in_op  input  2  0=MUL (low half), 1=MULH (high half), 2=DIV, 3=REM
in_signed  input  1  1=two's-complement operands
in_a  input  WIDTH  multiplicand / dividend
in_b  input  WIDTH  multiplier / divisor
in_tag  input  TAG_W  opaque tag, returned with result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_tag  output  TAG_W  tag of this result
out_dbz  output  1  divide-by-zero flag (DIV/REM only)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0 while reset is asserted, 1 in the first cycle after release; out_valid=0, out_result=0, out_tag=0, out_dbz=0, busy=0; FSM=IDLE.
- FSM states: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
- IDLE: in_ready=1. If in_valid is high at an edge, latch op, signed, a, b and tag, then go to PREP.
- PREP (1 cycle): if signed, take the absolute values of a and b; record result sign.
  - Sign is a^b for MUL/MULH/DIV; sign of a for REM.
  - Clear the 2*WIDTH accumulator and the bit counter.
- RUN (exactly WIDTH cycles): one step per cycle.
  - Multiply: shift-add.
  - Divide: restoring; quotient bit = 1 when the partial remainder >= divisor.
  - Counter is $clog2(WIDTH)+1 bits; exit when it reaches WIDTH-1.
- FIX (1 cycle): apply sign correction by two's-complement negation of the full 2*WIDTH product or of the quotient/remainder. Select the output word and register out_result, out_tag and out_dbz.
- DONE: out_valid=1, outputs held stable. On out_valid&&out_ready go to IDLE. in_ready rises in that next cycle; there is no same-cycle re-accept.
- Latency: out_valid rises WIDTH+3 edges after the accepting edge (35 for WIDTH=32), independent of operand values.
- Backpressure: DONE is held indefinitely while out_ready=0; no new request is accepted.
- Divide by zero (b==0): DIV returns all ones; REM returns a, unmodified. out_dbz=1. Latency is unchanged.
- Signed overflow (a=most negative, b=-1, signed DIV): quotient = a, REM = 0, out_dbz=0.
- MUL low half is identical for signed and unsigned. MULH differs by signedness.
- out_dbz=0 for MUL/MULH.
- in_a, in_b and in_tag are ignored outside the IDLE accept edge.
- Reset asserted mid-operation: operation is discarded, no result is produced, and all outputs go to reset values asynchronously.

Optional Feature:
CALC_MULDIV_EARLY_OUT_EN
- Defined: in PREP, if either multiply operand is 0, or the divisor is 0, or |a|<|b| for DIV/REM, skip RUN and go straight to FIX with the result computed directly. Latency becomes 3 edges.
- Undefined: fixed WIDTH+3 latency in all cases. This is the default.

Decomposition:
- Package calc_pkg holds:
  - op encodings OP_MUL/OP_MULH/OP_DIV/OP_REM;
  - the FSM state enum (ST_IDLE, ST_PREP, ST_RUN, ST_FIX, ST_DONE);
  - localparam CNT_W = $clog2(WIDTH)+1.
- One sub-module is natural: calc_negate_abs, a combinational conditional two's-complement of width N. It is used in PREP and FIX.

Test Plan:
- Unsigned MUL 7×6 -> out_result=42 after exactly 35 edges; out_tag echoes 5'h0A; out_dbz=0.
- Signed -3×5 -> MUL=0xFFFFFFF1, MULH=0xFFFFFFFF. Unsigned MULH 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 100/7 -> 14; REM -> 2. Signed DIV -100/7 -> 0xFFFFFFF2 (-14). Signed REM -100/7 -> 0xFFFFFFFE (-2).
- DIV 5/0 -> 0xFFFFFFFF with out_dbz=1; REM 5/0 -> 5 with out_dbz=1. Signed DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Hold out_ready=0 for 20 cycles after out_valid -> result stable, in_ready=0, a new in_valid is ignored. Release -> one handshake, then in_ready=1 on the next cycle.
- Assert reset at cycle 10 of RUN -> out_valid and busy=0 immediately. After release, a fresh 9×9 -> 81 with correct latency.
